fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core: holds the architectural fetch PC, selects the next PC, and registers the fetched word into the IF/ID pipeline register. Next-PC sources are:
- sequential PC+4;
- the branch target computed in D (already resolved to target or PC+8 for the delay slot);
- the J-type jump target;
- the jr register value;
- the exception handler entry;
- EPC on eret.

Detects fetch address errors (AdEL) and forwards them down the pipe with the instruction.

---
 rtl/cpu_defs.sv | 38 +++
 rtl/fetch_stage_if.sv | 34 +++
 rtl/if_id_reg.sv | 23 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core front end.
// Contents: next-PC select encodings, IF/ID exception codes, default
// address map constants, the IF/ID record layout and the fetch
// address-error predicate.
package cpu_defs;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_TOP     = 32'h0000_6FFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  exc;
    logic        bd;
  } if_id_t;

  // AdEL on instruction fetch: word misalignment or outside the IM window
  // (unsigned compare, bounds inclusive).
  function automatic logic fetch_addr_err(input logic [31:0] pc,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and the rest of the core.
// slave  : the fetch stage (consumes redirects/stall/IM data, drives
//          fetch address and the IF/ID register contents)
// master : the surrounding core (hazard unit, D stage, CP0, IM)
interface fetch_stage_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [31:0] branch;
  logic [31:0] jump;
  logic [31:0] jr_target;
  logic        br_d;
  logic        int_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] instr_in;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic [4:0]  exc_d;
  logic        bd_d;

  modport slave (
    input  stall, npc_sel, branch, jump, jr_target, br_d,
           int_req, eret, epc, instr_in,
    output pc_f, instr_d, pc_d, pc4_d, exc_d, bd_d
  );

  modport master (
    output stall, npc_sel, branch, jump, jr_target, br_d,
           int_req, eret, epc, instr_in,
    input  pc_f, instr_d, pc_d, pc4_d, exc_d, bd_d
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports: clk, reset (sync, active-high, clears), en (load when high),
//        flush (clears, beats en), d (next record), q (registered record).
module if_id_reg
  import cpu_defs::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: architectural fetch PC, next-PC selection and
// the IF/ID register, with AdEL detection carried along the instruction.
// Ports: clk, reset (sync, active-high); fif (fetch_stage_if.slave):
//   in : stall, npc_sel, branch, jump, jr_target, br_d, int_req, eret,
//        epc, instr_in
//   out: pc_f, instr_d, pc_d, pc4_d, exc_d, bd_d
module fetch_stage #(
  parameter logic [31:0] PC_RESET   = cpu_defs::PC_RESET,
  parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
  parameter logic [31:0] IM_BASE    = cpu_defs::IM_BASE,
  parameter logic [31:0] IM_TOP     = cpu_defs::IM_TOP
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  fif
);

  logic [31:0]      pc_p0;
  logic [31:0]      pc4_p0;
  logic [31:0]      pc_nxt;
  logic [31:0]      fetch_word_p0;
  logic             adel_p0;
  cpu_defs::if_id_t ifid_nxt;
  cpu_defs::if_id_t ifid_p1;

  // ---- stage p0: fetch address, AdEL check, next-PC mux ----
  assign pc4_p0        = pc_p0 + 32'd4;
  assign adel_p0       = cpu_defs::fetch_addr_err(pc_p0, IM_BASE, IM_TOP);
  // A faulting fetch never lets IM data into the pipe; it travels as a nop.
  assign fetch_word_p0 = adel_p0 ? 32'h0 : fif.instr_in;

  always_comb begin
    pc_nxt = pc4_p0;
    if (fif.int_req) begin
      pc_nxt = HANDLER_PC;
    end else if (fif.eret) begin
      pc_nxt = fif.epc;
    end else if (fif.stall) begin
      pc_nxt = pc_p0;
    end else begin
      case (cpu_defs::npc_sel_e'(fif.npc_sel))
        cpu_defs::NPC_SEQ: pc_nxt = pc4_p0;
        cpu_defs::NPC_BR:  pc_nxt = fif.branch;
        cpu_defs::NPC_J:   pc_nxt = fif.jump;
        cpu_defs::NPC_JR:  pc_nxt = fif.jr_target;
        default:           pc_nxt = pc4_p0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= PC_RESET;
    end else begin
      pc_p0 <= pc_nxt;
    end
  end

  always_comb begin
    ifid_nxt       = '0;
    ifid_nxt.instr = fetch_word_p0;
    ifid_nxt.pc    = pc_p0;
    ifid_nxt.pc4   = pc4_p0;
    ifid_nxt.exc   = adel_p0 ? cpu_defs::EXC_ADEL : cpu_defs::EXC_NONE;
    ifid_nxt.bd    = fif.br_d;
  end

  // ---- stage p1: IF/ID register ----
  // Exception entry and eret both discard the fetched word; eret has no
  // delay slot, so nothing behind it survives.
  if_id_reg u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (!fif.stall),
    .flush (fif.int_req || fif.eret),
    .d     (ifid_nxt),
    .q     (ifid_p1)
  );

  assign fif.pc_f    = pc_p0;
  assign fif.instr_d = ifid_p1.instr;
  assign fif.pc_d    = ifid_p1.pc;
  assign fif.pc4_d   = ifid_p1.pc4;
  assign fif.exc_d   = ifid_p1.exc;
  assign fif.bd_d    = ifid_p1.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, a hand-written stall
// sequence, and randomized stimulus against a behavioural model.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  fetch_stage_if fif ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: a fixed scramble of the address.
  function automatic logic [31:0] im(input logic [31:0] a);
    return ((a ^ 32'hA5A5_0000) * 32'h0001_0003) + 32'h0000_1357;
  endfunction

  always_comb fif.instr_in = im(fif.pc_f);

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] branch;
    logic [31:0] jump;
    logic [31:0] jr;
    logic [31:0] epc;
    logic        br_d;
    logic        int_req;
    logic        eret;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [4:0]  exc;
    logic        bd;
    logic        izero;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [4:0]  exc;
    logic        bd;
  } mstate_t;

  // Unselected target buses carry distinct legal decoys so a wrong mux
  // choice shows up as a wrong pc_f.
  function automatic stim_t mk(input logic rst, input logic stall,
                               input logic [1:0] sel, input logic [31:0] tgt,
                               input logic br_d, input logic int_req,
                               input logic eret);
    stim_t s;
    s.rst     = rst;
    s.stall   = stall;
    s.sel     = sel;
    s.branch  = (sel == 2'd1) ? tgt : 32'h0000_5A00;
    s.jump    = (sel == 2'd2) ? tgt : 32'h0000_5B00;
    s.jr      = (sel == 2'd3) ? tgt : 32'h0000_5C00;
    s.epc     = eret ? tgt : 32'h0000_5D00;
    s.br_d    = br_d;
    s.int_req = int_req;
    s.eret    = eret;
    return s;
  endfunction

  function automatic vec_t v(input stim_t s, input logic [31:0] pc_f,
                             input logic [31:0] pc_d, input logic [31:0] pc4_d,
                             input logic [4:0] exc, input logic bd,
                             input logic izero);
    vec_t r;
    r.s = s; r.pc_f = pc_f; r.pc_d = pc_d; r.pc4_d = pc4_d;
    r.exc = exc; r.bd = bd; r.izero = izero;
    return r;
  endfunction

  // Behavioural reference: one clock edge of the fetch stage.
  function automatic mstate_t model_next(input mstate_t m, input stim_t s);
    mstate_t n;
    logic    bad;
    bad = (m.pc % 4 != 0) || (m.pc < 32'h3000) || (m.pc > 32'h6FFC);
    n = m;
    if (s.rst) begin
      n = '0;
      n.pc = 32'h3000;
    end else if (s.int_req || s.eret) begin
      n = '0;
      n.pc = s.int_req ? 32'h4180 : s.epc;
    end else if (!s.stall) begin
      if (s.sel == 2'd1)      n.pc = s.branch;
      else if (s.sel == 2'd2) n.pc = s.jump;
      else if (s.sel == 2'd3) n.pc = s.jr;
      else                    n.pc = m.pc + 4;
      n.pc_d  = m.pc;
      n.pc4_d = m.pc + 4;
      n.instr = bad ? 32'h0 : im(m.pc);
      n.exc   = bad ? 5'd4 : 5'd0;
      n.bd    = s.br_d;
    end
    return n;
  endfunction

  function automatic logic [31:0] rand_tgt();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r <= 4) return 32'h3000 + {18'd0, 12'($urandom_range(0, 32'hFFF)), 2'b00};
    if (r == 5) return 32'h3000 + {18'd0, 12'($urandom_range(0, 32'hFFF)), 2'($urandom_range(1, 3))};
    if (r == 6) return 32'h7000 + 32'($urandom_range(0, 32'hFFFF));
    return 32'($urandom_range(0, 32'h2FFF));
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    reset         = s.rst;
    fif.stall     = s.stall;
    fif.npc_sel   = s.sel;
    fif.branch    = s.branch;
    fif.jump      = s.jump;
    fif.jr_target = s.jr;
    fif.epc       = s.epc;
    fif.br_d      = s.br_d;
    fif.int_req   = s.int_req;
    fif.eret      = s.eret;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc_f,
                         input logic [31:0] instr, input logic [31:0] pc_d,
                         input logic [31:0] pc4_d, input logic [4:0] exc,
                         input logic bd);
    chk({tag, ".pc_f"},    fif.pc_f,           pc_f);
    chk({tag, ".instr_d"}, fif.instr_d,        instr);
    chk({tag, ".pc_d"},    fif.pc_d,           pc_d);
    chk({tag, ".pc4_d"},   fif.pc4_d,          pc4_d);
    chk({tag, ".exc_d"},   {27'd0, fif.exc_d}, {27'd0, exc});
    chk({tag, ".bd_d"},    {31'd0, fif.bd_d},  {31'd0, bd});
  endtask

  vec_t    tbl[$];
  stim_t   sq;
  stim_t   rs;
  mstate_t m;
  mstate_t e;

  initial begin
    reset = 1'b1;
    fif.stall = 1'b0; fif.npc_sel = 2'd0; fif.branch = '0; fif.jump = '0;
    fif.jr_target = '0; fif.epc = '0; fif.br_d = 1'b0;
    fif.int_req = 1'b0; fif.eret = 1'b0;

    sq = mk(0, 0, 0, 32'h0, 0, 0, 0);
    tbl.push_back(v(sq,                                 32'h3004, 32'h3000, 32'h3004, 0, 0, 0));
    tbl.push_back(v(sq,                                 32'h3008, 32'h3004, 32'h3008, 0, 0, 0));
    tbl.push_back(v(mk(0, 0, 1, 32'h3040, 1, 0, 0),     32'h3040, 32'h3008, 32'h300C, 0, 1, 0));
    tbl.push_back(v(mk(0, 1, 2, 32'h3100, 0, 0, 0),     32'h3040, 32'h3008, 32'h300C, 0, 1, 0));
    tbl.push_back(v(mk(0, 1, 2, 32'h3100, 0, 0, 0),     32'h3040, 32'h3008, 32'h300C, 0, 1, 0));
    tbl.push_back(v(mk(0, 0, 2, 32'h3100, 0, 0, 0),     32'h3100, 32'h3040, 32'h3044, 0, 0, 0));
    tbl.push_back(v(mk(0, 1, 0, 32'h0, 0, 1, 0),        32'h4180, 32'h0,    32'h0,    0, 0, 1));
    tbl.push_back(v(mk(0, 0, 0, 32'h3010, 0, 0, 1),     32'h3010, 32'h0,    32'h0,    0, 0, 1));
    tbl.push_back(v(sq,                                 32'h3014, 32'h3010, 32'h3014, 0, 0, 0));
    tbl.push_back(v(mk(0, 0, 3, 32'h3002, 0, 0, 0),     32'h3002, 32'h3014, 32'h3018, 0, 0, 0));
    tbl.push_back(v(sq,                                 32'h3006, 32'h3002, 32'h3006, 4, 0, 1));
    tbl.push_back(v(mk(0, 0, 3, 32'h7000, 0, 0, 0),     32'h7000, 32'h3006, 32'h300A, 4, 0, 1));
    tbl.push_back(v(sq,                                 32'h7004, 32'h7000, 32'h7004, 4, 0, 1));
    tbl.push_back(v(mk(0, 0, 0, 32'h3010, 0, 1, 1),     32'h4180, 32'h0,    32'h0,    0, 0, 1));
    tbl.push_back(v(sq,                                 32'h4184, 32'h4180, 32'h4184, 0, 0, 0));
    tbl.push_back(v(mk(1, 0, 2, 32'h3100, 1, 0, 0),     32'h3000, 32'h0,    32'h0,    0, 0, 1));
    tbl.push_back(v(mk(0, 0, 3, 32'hFFFF_FFFC, 0, 0, 0), 32'hFFFF_FFFC, 32'h3000, 32'h3004, 0, 0, 0));
    tbl.push_back(v(sq,                                 32'h0,    32'hFFFF_FFFC, 32'h0, 4, 0, 1));
    tbl.push_back(v(sq,                                 32'h4,    32'h0,    32'h4,    4, 0, 1));
    tbl.push_back(v(mk(0, 0, 3, 32'h6FFC, 0, 0, 0),     32'h6FFC, 32'h4,    32'h8,    4, 0, 1));
    tbl.push_back(v(sq,                                 32'h7000, 32'h6FFC, 32'h7000, 0, 0, 0));
    tbl.push_back(v(mk(0, 0, 3, 32'h2FFC, 0, 0, 0),     32'h2FFC, 32'h7000, 32'h7004, 4, 0, 1));
    tbl.push_back(v(sq,                                 32'h3000, 32'h2FFC, 32'h3000, 4, 0, 1));
    tbl.push_back(v(mk(1, 1, 0, 32'h0, 0, 0, 0),        32'h3000, 32'h0,    32'h0,    0, 0, 1));
    tbl.push_back(v(sq,                                 32'h3004, 32'h3000, 32'h3004, 0, 0, 0));
    tbl.push_back(v(mk(0, 1, 0, 32'h3020, 0, 0, 1),     32'h3020, 32'h0,    32'h0,    0, 0, 1));

    // Reset state
    apply(mk(1, 0, 0, 32'h0, 0, 0, 0));
    apply(mk(1, 0, 0, 32'h0, 0, 0, 0));
    chk_all("reset", 32'h3000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].s);
      chk_all($sformatf("vec%0d", i), tbl[i].pc_f,
              tbl[i].izero ? 32'h0 : im(tbl[i].pc_d),
              tbl[i].pc_d, tbl[i].pc4_d, tbl[i].exc, tbl[i].bd);
    end

    // Three-cycle stall holding a pending branch, then release
    apply(sq);
    chk_all("st_pre", 32'h3024, im(32'h3020), 32'h3020, 32'h3024, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 1, 1, 32'h3200, 1, 0, 0));
      chk_all($sformatf("st_hold%0d", k), 32'h3024, im(32'h3020),
              32'h3020, 32'h3024, 5'd0, 1'b0);
    end
    apply(mk(0, 0, 1, 32'h3200, 1, 0, 0));
    chk_all("st_rel", 32'h3200, im(32'h3024), 32'h3024, 32'h3028, 5'd0, 1'b1);
    apply(sq);
    chk_all("st_post", 32'h3204, im(32'h3200), 32'h3200, 32'h3204, 5'd0, 1'b0);

    // Randomized run against the model
    apply(mk(1, 0, 0, 32'h0, 0, 0, 0));
    m = '0;
    m.pc = 32'h3000;
    for (int t = 0; t < 600; t++) begin
      rs.rst     = ($urandom_range(0, 39) == 0);
      rs.stall   = ($urandom_range(0, 3) == 0);
      rs.sel     = 2'($urandom_range(0, 3));
      rs.branch  = rand_tgt();
      rs.jump    = rand_tgt();
      rs.jr      = rand_tgt();
      rs.epc     = rand_tgt();
      rs.br_d    = 1'($urandom_range(0, 1));
      rs.int_req = ($urandom_range(0, 19) == 0);
      rs.eret    = ($urandom_range(0, 19) == 0);
      e = model_next(m, rs);
      apply(rs);
      chk_all($sformatf("rnd%0d", t), e.pc, e.instr, e.pc_d, e.pc4_d, e.exc, e.bd);
      m = e;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
